// File: rtl/taillight_input_conditioner_if.sv
// rtl/taillight_input_conditioner_if.sv - raw input and conditioned output bundle for the input conditioner
interface taillight_input_conditioner_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic            hazard;

    // Board side: drives the raw switches and consumes the clean levels/pulses.
    modport master (
        output raw_in,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  hazard
    );

    // Conditioner side.
    modport slave (
        input  raw_in,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output hazard
    );
endinterface

// File: rtl/taillight_input_conditioner.sv
// rtl/taillight_input_conditioner.sv - per-channel synchronizer and debounce FSM with edge pulses and hazard flag
module taillight_input_conditioner #(
    parameter int N_CH            = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    taillight_input_conditioner_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] rise_vec;
    logic [N_CH-1:0] fall_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   synced;
        state_t                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        // Shift the asynchronous input through the metastability chain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in[i]};
            end
        end

        assign synced = sync_q[SYNC_STAGES-1];

        // Debounce state, stability counter and registered outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Accept a level change only after CNT_LAST+1 consecutive agreeing samples;
        // any disagreement drops back to the stable state and the count restarts.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                STABLE_LO: begin
                    cnt_d = '0;
                    if (synced) begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!synced) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    cnt_d = '0;
                    if (!synced) begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (synced) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign level_vec[i] = level_q;
        assign rise_vec[i]  = rise_q;
        assign fall_vec[i]  = fall_q;
    end

    assign bus.level_out  = level_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.fall_pulse = fall_vec;
    // Both turn signals debounced high at once means the hazard switch combination.
    assign bus.hazard     = level_vec[0] & level_vec[1];
endmodule

// File: doc/taillight_input_conditioner.md
# taillight_input_conditioner

Synchronizes and debounces raw board inputs (turn-signal switches, brake button) before they reach the taillight sequencers. Sits directly upstream of the taillight top level. Per channel it delivers a clean level plus single-cycle rise/fall pulses, so the taillight FSMs never see metastable or bouncing inputs. Runs on the fast board clock, not the divided 1 Hz clock.

## Interface
- `N_CH`, 3: number of independent input channels.
  - Top-level map: bit0 = right turn (`sw[0]`), bit1 = left turn (`sw[15]`), bit2 = brake (`btnC`).
- `SYNC_STAGES`, 2: synchronizer flop depth per channel; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); must be ≥ 2.
- `clk` input 1: board clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Top level drives it with `~btnU`.
- `raw_in` input `N_CH`: asynchronous, bouncing inputs.
- `level_out` output `N_CH`: debounced level per channel.
- `rise_pulse` output `N_CH`: one-cycle pulse when `level_out[i]` goes 0→1.
- `fall_pulse` output `N_CH`: one-cycle pulse when `level_out[i]` goes 1→0.
- `hazard` output 1: high while `level_out[0]` and `level_out[1]` are both 1.

## Operation
- Per channel: a `SYNC_STAGES`-deep flop chain, then a debounce FSM with a counter of width `$clog2(DEBOUNCE_CYCLES)`.
- FSM states:
  - STABLE_LO: level 0; counter held at 0.
    - Synced input = 1 → WAIT_HI, counter = 1.
  - WAIT_HI: level 0.
    - Synced input = 0 → STABLE_LO, counter = 0. No pulse.
    - Synced input = 1 and counter = `DEBOUNCE_CYCLES`-1 → STABLE_HI; level becomes 1; rise pulse for one cycle.
    - Otherwise the counter increments.
  - STABLE_HI and WAIT_LO: mirror of the two states above, with fall pulse.
- The counter never exceeds `DEBOUNCE_CYCLES`-1. No wrap-around is possible.
- Any glitch shorter than `DEBOUNCE_CYCLES` synced cycles is fully rejected. The counter restarts from 1 on the next change.
- The pulse is asserted in the same cycle the level flips. Rise and fall pulses are mutually exclusive per channel.
- Channels are fully independent; simultaneous changes on several channels are each processed normally.
- `hazard` is combinational from the registered levels: the AND of bit0 and bit1. It is not a pulse.
- Reset (asynchronous, any time, including mid-WAIT):
  - All sync flops, counters and levels go to 0; state goes to STABLE_LO.
  - All pulses and `hazard` go to 0 immediately.
  - No pulse is emitted on reset entry or exit.
- An input already high at reset release is treated as a fresh 0→1 change. It produces a rise pulse after the full latency.

## Timing
- Latency: a `raw_in` change sampled at edge k, then held stable, updates `level_out` and the pulse at edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1.
  - Defaults: 1_000_001 cycles.
- Pulse width is exactly 1 clk cycle.
- Minimum spacing between two accepted changes on one channel is `DEBOUNCE_CYCLES` cycles.
- `hazard` follows `level_out` with zero additional cycles.
- All outputs except `hazard` are registered.
- All outputs are 0 during reset and in the first cycle after release.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.

- Clean step: `raw_in[2]` 0→1 sampled at edge 10, then held.
  - `level_out[2]`=1 and `rise_pulse[2]`=1 at edge 15 only.
  - `rise_pulse[2]` is 0 at edge 16.
- Bounce rejection: `raw_in[0]` toggles high 2 cycles, low 1, high 3, low.
  - `level_out[0]` stays 0; no pulses.
- Release: from debounced high, `raw_in[1]` 1→0 held.
  - `fall_pulse[1]` for one cycle exactly 5 edges later.
  - `level_out[1]`=0.
- Hazard: raise `raw_in[0]` and `raw_in[1]` on the same edge.
  - Both rise pulses coincide.
  - `hazard`=1 in that same cycle; returns to 0 when either channel falls.
- Reset mid-operation: assert `reset`=0 with `raw_in[2]` in WAIT_HI (counter=2).
  - All outputs 0 asynchronously, before the next edge.
  - After release with input still high: rise pulse 5 edges later, and no other pulse.
- Reset with inputs high: hold `raw_in`=3'b111 through reset.
  - After release, all three rise pulses fire together exactly once.
  - `hazard`=1 from then on.
